// File: rtl/sys_host_cmd_pkg.sv
// Shared definitions for the host command initiator:
// command bytes, request encodings, FSM states.
package sys_host_cmd_pkg;

  localparam logic [7:0] CMD_WR  = 8'hAA;
  localparam logic [7:0] CMD_RD  = 8'hBB;
  localparam logic [7:0] CMD_ALU = 8'hCC;
  localparam logic [7:0] CMD_NOP = 8'hDD;

  typedef enum logic [1:0] {
    REQ_WR  = 2'd0,
    REQ_RD  = 2'd1,
    REQ_ALU = 2'd2,
    REQ_NOP = 2'd3
  } req_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_RSP_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sys_host_cmd.sv
// Serializes one host request into a UART command frame and
// gathers the 0/1/2 response bytes into a result word.
module sys_host_cmd
  import sys_host_cmd_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDR      = 4,
  parameter int TO_CYCLES = 4096
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ_VLD,
  input  logic [1:0]         REQ_TYPE,
  input  logic [ADDR-1:0]    REQ_ADDR,
  input  logic [WIDTH-1:0]   REQ_DATA_A,
  input  logic [WIDTH-1:0]   REQ_DATA_B,
  input  logic [3:0]         REQ_FUN,
  output logic               REQ_RDY,
  output logic [WIDTH-1:0]   TX_DATA,
  output logic               TX_VLD,
  input  logic               TX_BUSY,
  input  logic [WIDTH-1:0]   RX_DATA,
  input  logic               RX_VLD,
  output logic [2*WIDTH-1:0] RSP_DATA,
  output logic               RSP_VLD,
  output logic               RSP_ERR
);

  localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [3:0][WIDTH-1:0]   frm_q, frm_d;
  logic [1:0]              last_q, last_d;
  logic [1:0]              idx_q, idx_d;
  logic [1:0]              nrsp_q, nrsp_d;
  logic                    rxc_q, rxc_d;
  logic [WIDTH-1:0]        lo_q, lo_d;
  logic [WIDTH-1:0]        hi_q, hi_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [WIDTH-1:0]        tx_data_q, tx_data_d;
  logic                    tx_vld_q, tx_vld_d;
  logic                    rsp_vld_q, rsp_vld_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [2*WIDTH-1:0]      rsp_data_q, rsp_data_d;
  logic                    fin, fin_err, to_hit;

  assign REQ_RDY  = (state_q == ST_IDLE);
  assign TX_DATA  = tx_data_q;
  assign TX_VLD   = tx_vld_q;
  assign RSP_DATA = rsp_data_q;
  assign RSP_VLD  = rsp_vld_q;
  assign RSP_ERR  = rsp_err_q;
  assign to_hit   = (cnt_q == TO_LAST);

  always_comb begin
    state_d    = state_q;
    frm_d      = frm_q;
    last_d     = last_q;
    idx_d      = idx_q;
    nrsp_d     = nrsp_q;
    rxc_d      = rxc_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_vld_d   = 1'b0;
    rsp_vld_d  = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_data_d = rsp_data_q;
    fin        = 1'b0;
    fin_err    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (REQ_VLD) begin
          frm_d      = '0;
          idx_d      = '0;
          rxc_d      = 1'b0;
          lo_d       = '0;
          hi_d       = '0;
          rsp_data_d = '0;
          state_d    = ST_SEND;
          unique case (req_type_e'(REQ_TYPE))
            REQ_WR: begin
              frm_d[0] = WIDTH'(CMD_WR);
              frm_d[1] = WIDTH'(REQ_ADDR);
              frm_d[2] = REQ_DATA_A;
              last_d   = 2'd2;
              nrsp_d   = 2'd0;
            end
            REQ_RD: begin
              frm_d[0] = WIDTH'(CMD_RD);
              frm_d[1] = WIDTH'(REQ_ADDR);
              last_d   = 2'd1;
              nrsp_d   = 2'd1;
            end
            REQ_ALU: begin
              frm_d[0] = WIDTH'(CMD_ALU);
              frm_d[1] = REQ_DATA_A;
              frm_d[2] = REQ_DATA_B;
              frm_d[3] = WIDTH'(REQ_FUN);
              last_d   = 2'd3;
              nrsp_d   = 2'd2;
            end
            REQ_NOP: begin
              frm_d[0] = WIDTH'(CMD_NOP);
              frm_d[1] = WIDTH'(REQ_FUN);
              last_d   = 2'd1;
              nrsp_d   = 2'd2;
            end
          endcase
        end
      end
      ST_SEND: begin
        cnt_d = '0;
        if (!TX_BUSY) begin
          tx_vld_d  = 1'b1;
          tx_data_d = frm_q[idx_q];
          state_d   = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        cnt_d = cnt_q + 16'd1;
        if (TX_BUSY) begin
          cnt_d   = '0;
          state_d = ST_WAIT_LO;
        end else if (to_hit) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      ST_WAIT_LO: begin
        cnt_d = cnt_q + 16'd1;
        if (!TX_BUSY) begin
          cnt_d = '0;
          if (idx_q != last_q) begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_SEND;
          end else if (nrsp_q == 2'd0) begin
            fin = 1'b1;
          end else begin
            state_d = ST_RSP_WAIT;
          end
        end else if (to_hit) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      ST_RSP_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (RX_VLD) begin
          cnt_d = '0;
          if (rxc_q) hi_d = RX_DATA;
          else       lo_d = RX_DATA;
          rxc_d = 1'b1;
          fin   = ({1'b0, rxc_q} == nrsp_q - 2'd1);
        end else if (to_hit) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // completion is flagged on entry to DONE so the pulse spans DONE
    if (fin) begin
      state_d    = ST_DONE;
      cnt_d      = '0;
      rsp_vld_d  = 1'b1;
      rsp_err_d  = fin_err;
      rsp_data_d = fin_err ? '0 : {hi_d, lo_d};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      frm_q      <= '0;
      last_q     <= '0;
      idx_q      <= '0;
      nrsp_q     <= '0;
      rxc_q      <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      frm_q      <= frm_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      nrsp_q     <= nrsp_d;
      rxc_q      <= rxc_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_vld_q   <= tx_vld_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_sys_host_cmd.sv
// Scoreboard bench for sys_host_cmd: directed requests, a UART TX
// busy model, and a negedge monitor checking bytes and responses.
`timescale 1ns/1ps
module tb_sys_host_cmd;
  import sys_host_cmd_pkg::*;

  localparam int W  = 8;
  localparam int A  = 4;
  localparam int TO = 32;

  typedef enum int { K_FALL, K_RX, K_TO } kind_e;
  typedef struct { logic [W-1:0] b; int c; } tx_exp_t;
  typedef struct { logic [2*W-1:0] d; logic e; kind_e k; } rsp_exp_t;

  logic           clk = 0;
  logic           rst_n = 0;
  logic           req_vld = 0;
  logic [1:0]     req_type = 0;
  logic [A-1:0]   req_addr = 0;
  logic [W-1:0]   req_a = 0;
  logic [W-1:0]   req_b = 0;
  logic [3:0]     req_fun = 0;
  logic           req_rdy;
  logic [W-1:0]   tx_data;
  logic           tx_vld;
  logic           tx_busy_m = 0;
  logic           hold_busy = 0;
  logic           tx_busy;
  logic [W-1:0]   rx_data = 0;
  logic           rx_vld = 0;
  logic [2*W-1:0] rsp_data;
  logic           rsp_vld;
  logic           rsp_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_fall = 0;
  int last_rx = 0;

  tx_exp_t  exp_tx[$];
  rsp_exp_t exp_rsp[$];

  assign tx_busy = tx_busy_m | hold_busy;

  sys_host_cmd #(.WIDTH(W), .ADDR(A), .TO_CYCLES(TO)) dut (
    .CLK(clk), .RST(rst_n),
    .REQ_VLD(req_vld), .REQ_TYPE(req_type), .REQ_ADDR(req_addr),
    .REQ_DATA_A(req_a), .REQ_DATA_B(req_b), .REQ_FUN(req_fun),
    .REQ_RDY(req_rdy),
    .TX_DATA(tx_data), .TX_VLD(tx_vld), .TX_BUSY(tx_busy),
    .RX_DATA(rx_data), .RX_VLD(rx_vld),
    .RSP_DATA(rsp_data), .RSP_VLD(rsp_vld), .RSP_ERR(rsp_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // UART TX: busy for 10 cycles after each accepted byte
  initial forever begin
    @(negedge clk);
    if (rst_n && tx_vld) begin
      @(posedge clk);
      #1 tx_busy_m = 1;
      repeat (10) @(posedge clk);
      #1 tx_busy_m = 0;
      last_fall = cyc;
    end
  end

  initial begin : monitor
    tx_exp_t  te;
    rsp_exp_t re;
    int       want;
    forever begin
      @(negedge clk);
      if (rst_n && tx_vld) begin
        chk("tx_vld_while_busy", 32'(tx_busy), 32'd0);
        if (exp_tx.size() == 0) begin
          chk("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          te = exp_tx.pop_front();
          chk("tx_byte", 32'(tx_data), 32'(te.b));
          if (te.c >= 0) chk("tx_first_lat", 32'(cyc), 32'(te.c));
        end
      end
      if (rst_n && rsp_vld) begin
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
        end else begin
          re = exp_rsp.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(re.d));
          chk("rsp_err", 32'(rsp_err), 32'(re.e));
          case (re.k)
            K_FALL:  want = last_fall + 1;
            K_RX:    want = last_rx + 1;
            default: want = last_rx + TO + 1;
          endcase
          chk("rsp_lat", 32'(cyc), 32'(want));
        end
      end
    end
  end

  task automatic push_tx(input logic [W-1:0] b, input int c);
    tx_exp_t t;
    t.b = b;
    t.c = c;
    exp_tx.push_back(t);
  endtask

  task automatic push_rsp(input logic [2*W-1:0] d, input logic e,
                          input kind_e k);
    rsp_exp_t r;
    r.d = d;
    r.e = e;
    r.k = k;
    exp_rsp.push_back(r);
  endtask

  // frame bytes are pushed here; first byte timed unless TX is held
  task automatic do_req(input logic [1:0] t, input logic [A-1:0] ad,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] f, input logic [W-1:0] b0,
                        input logic [W-1:0] b1, input logic [W-1:0] b2,
                        input logic [W-1:0] b3, input int n);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (req_rdy) begin
        ok = 1;
        break;
      end
    end
    chk("req_rdy_wait", 32'(ok), 32'd1);
    push_tx(b0, hold_busy ? -1 : cyc + 2);
    push_tx(b1, -1);
    if (n > 2) push_tx(b2, -1);
    if (n > 3) push_tx(b3, -1);
    req_vld = 1;
    req_type = t;
    req_addr = ad;
    req_a = a;
    req_b = b;
    req_fun = f;
    @(posedge clk);
    #1;
    req_vld = 0;
    req_type = 2'($urandom);
    req_addr = 4'($urandom);
    req_a = 8'($urandom);
    req_b = 8'($urandom);
    req_fun = 4'($urandom);
  endtask

  task automatic wait_tx_idle();
    bit ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2;
      if (exp_tx.size() == 0 && !tx_busy) begin
        ok = 1;
        break;
      end
    end
    chk("tx_drain", 32'(ok), 32'd1);
  endtask

  task automatic send_rx(input logic [W-1:0] b);
    @(posedge clk);
    #1;
    rx_vld = 1;
    rx_data = b;
    last_rx = cyc;
    @(posedge clk);
    #1;
    rx_vld = 0;
  endtask

  task automatic wait_rsp();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (exp_rsp.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("rsp_wait", 32'(ok), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_req_rdy"}, 32'(req_rdy), 32'd1);
    chk({tag, "_tx_vld"}, 32'(tx_vld), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_rsp_vld"}, 32'(rsp_vld), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    chk_reset_vals("rst");
    @(posedge clk);
    #1 rst_n = 1;

    // write addr 3 <- 5A
    push_rsp(16'h0000, 1'b0, K_FALL);
    do_req(2'd0, 4'd3, 8'h5A, 8'h00, 4'd0,
           8'hAA, 8'h03, 8'h5A, 8'h00, 3);
    wait_tx_idle();
    wait_rsp();

    // read addr 2 -> 3C
    do_req(2'd1, 4'd2, 8'h00, 8'h00, 4'd0,
           8'hBB, 8'h02, 8'h00, 8'h00, 2);
    wait_tx_idle();
    push_rsp(16'h003C, 1'b0, K_RX);
    send_rx(8'h3C);
    wait_rsp();

    // ALU 10 + 20, fun 0 -> 0030
    do_req(2'd2, 4'd0, 8'h10, 8'h20, 4'd0,
           8'hCC, 8'h10, 8'h20, 8'h00, 4);
    wait_tx_idle();
    push_rsp(16'h0030, 1'b0, K_RX);
    send_rx(8'h30);
    send_rx(8'h00);
    wait_rsp();

    // ALU-nop fun 2, only one byte returned -> timeout
    do_req(2'd3, 4'd0, 8'h00, 8'h00, 4'd2,
           8'hDD, 8'h02, 8'h00, 8'h00, 2);
    wait_tx_idle();
    push_rsp(16'h0000, 1'b1, K_TO);
    send_rx(8'h11);
    wait_rsp();

    // TX held busy at acceptance, stray RX while in SEND
    @(posedge clk);
    #1 hold_busy = 1;
    do_req(2'd1, 4'd1, 8'h00, 8'h00, 4'd0,
           8'hBB, 8'h01, 8'h00, 8'h00, 2);
    repeat (5) @(posedge clk);
    send_rx(8'hEE);
    repeat (43) @(posedge clk);
    #1;
    chk("held_no_tx", 32'(exp_tx.size()), 32'd2);
    chk("held_no_rsp", 32'(rsp_vld), 32'd0);
    hold_busy = 0;
    wait_tx_idle();
    push_rsp(16'h0077, 1'b0, K_RX);
    send_rx(8'h77);
    wait_rsp();
    repeat (5) @(posedge clk);
    #1;
    chk("rsp_hold", 32'(rsp_data), 32'h0077);

    // reset during second byte of an ALU frame
    do_req(2'd2, 4'd0, 8'h44, 8'h55, 4'd3,
           8'hCC, 8'h44, 8'h55, 8'h03, 4);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (exp_tx.size() <= 2) begin
        ok = 1;
        break;
      end
    end
    chk("mid_frame_reach", 32'(ok), 32'd1);
    rst_n = 0;
    exp_tx.delete();
    chk_reset_vals("midrst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (!tx_busy) begin
        ok = 1;
        break;
      end
    end
    chk("post_rst_idle", 32'(ok), 32'd1);

    // read addr 7 -> A5 after the reset
    do_req(2'd1, 4'd7, 8'h00, 8'h00, 4'd0,
           8'hBB, 8'h07, 8'h00, 8'h00, 2);
    wait_tx_idle();
    push_rsp(16'h00A5, 1'b0, K_RX);
    send_rx(8'hA5);
    wait_rsp();

    repeat (40) @(posedge clk);
    #1;
    chk("tx_left", 32'(exp_tx.size()), 32'd0);
    chk("rsp_left", 32'(exp_rsp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
